// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage datapath.
// Each cycle it decides, from the current inputs and the registered state,
// which pipeline latches hold (stall_*) and which take a bubble (flush_*),
// and whether the PC advances. All decision outputs are combinational.
//
// Ports:
//   CLK, nRST                 clock (rising edge), asynchronous active-low reset
//   ifid_rs/ifid_rt           source registers of the decode instruction
//   ifid_uses_rt              decode instruction reads rt
//   idex_rd/idex_wen/idex_load  destination / write / load flags of EX instruction
//   exmem_rd/exmem_wen        destination / write flag of MEM instruction
//   ihit, dhit                icache / dcache hit
//   dmemREN, dmemWEN          MEM-stage data request
//   branch_taken, jump        redirect resolved in EX
//   halt                      halt instruction at MEM/WB
//   stall_{ifid,idex,xmem,wb} hold latch
//   flush_{ifid,idex,xmem,wb} load bubble into latch
//   pc_en                     PC update enable
//   halted                    processor halted (sticky until reset)
//   stall_cycles              saturating count of pc_en=0 cycles outside HALTED
module hazard_ctrl #(
  parameter int REG_W            = 5,
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int FORWARD_EN       = 1,
  parameter int CNT_W            = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic [REG_W-1:0] idex_rd,
  input  logic             idex_wen,
  input  logic             idex_load,
  input  logic [REG_W-1:0] exmem_rd,
  input  logic             exmem_wen,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmemREN,
  input  logic             dmemWEN,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             halt,
  output logic             stall_ifid,
  output logic             stall_idex,
  output logic             stall_xmem,
  output logic             stall_wb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_xmem,
  output logic             flush_wb,
  output logic             pc_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, BUBBLE, HALTED} state_t;

  localparam logic [2:0]       LU_RELOAD = 3'(LOAD_USE_BUBBLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       mem_busy, redirect, lu, raw;

  // Register 0 is hardwired to zero, so it never carries a dependency.
  function automatic logic dep(input logic [REG_W-1:0] rd,
                               input logic [REG_W-1:0] rs,
                               input logic [REG_W-1:0] rt,
                               input logic             uses_rt);
    return (rd != '0) && ((rd == rs) || (uses_rt && (rd == rt)));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  assign mem_busy = (dmemREN | dmemWEN) & ~dhit;
  assign redirect = branch_taken | jump;
  assign lu       = idex_load & idex_wen &
                    dep(idex_rd, ifid_rs, ifid_rt, ifid_uses_rt);
  assign raw      = (FORWARD_EN == 0) &&
                    ((idex_wen  && dep(idex_rd,  ifid_rs, ifid_rt, ifid_uses_rt)) ||
                     (exmem_wen && dep(exmem_rd, ifid_rs, ifid_rt, ifid_uses_rt)));

  always_comb begin
    stall_ifid = 1'b0;
    stall_idex = 1'b0;
    stall_xmem = 1'b0;
    stall_wb   = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    flush_xmem = 1'b0;
    flush_wb   = 1'b0;
    pc_en      = ihit;
    halted     = 1'b0;
    state_nxt  = state;
    cnt_nxt    = cnt;
    if (!nRST) begin
      // Every latch takes a bubble while reset is held.
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
      flush_xmem = 1'b1;
      flush_wb   = 1'b1;
      pc_en      = 1'b0;
      state_nxt  = RUN;
      cnt_nxt    = 3'd0;
    end else if (state == HALTED) begin
      stall_ifid = 1'b1;
      stall_idex = 1'b1;
      stall_xmem = 1'b1;
      stall_wb   = 1'b1;
      pc_en      = 1'b0;
      halted     = 1'b1;
    end else if (halt && !mem_busy) begin
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
      flush_xmem = 1'b1;
      pc_en      = 1'b0;
      state_nxt  = HALTED;
      cnt_nxt    = 3'd0;
    end else if (mem_busy) begin
      // Whole front end freezes; state and bubble count are held so a
      // pending load-use penalty resumes after the miss resolves.
      stall_ifid = 1'b1;
      stall_idex = 1'b1;
      stall_xmem = 1'b1;
      flush_wb   = 1'b1;
      pc_en      = 1'b0;
    end else if (redirect) begin
      // The stalled decode instruction is on the wrong path anyway.
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
      pc_en      = 1'b1;
      state_nxt  = RUN;
      cnt_nxt    = 3'd0;
    end else if (state == BUBBLE) begin
      stall_ifid = 1'b1;
      flush_idex = 1'b1;
      pc_en      = 1'b0;
      cnt_nxt    = cnt - 3'd1;
      if (cnt <= 3'd1) state_nxt = RUN;
    end else if (lu || raw) begin
      stall_ifid = 1'b1;
      flush_idex = 1'b1;
      pc_en      = 1'b0;
      if (lu && (LOAD_USE_BUBBLES > 1)) begin
        state_nxt = BUBBLE;
        cnt_nxt   = LU_RELOAD;
      end
    end else if (!ihit) begin
      flush_ifid = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= RUN;
      cnt          <= 3'd0;
      stall_cycles <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (!pc_en && (state != HALTED)) stall_cycles <= sat_inc(stall_cycles);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (forwarding/2 bubbles/32-bit count and
// no-forwarding/3 bubbles/4-bit count) share one stimulus stream. The driver
// pushes the reference model's expected outputs into per-instance queues;
// a monitor on the falling edge pops and compares.
module tb_hazard_ctrl;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       nRST;
  logic [4:0] ifid_rs, ifid_rt, idex_rd, exmem_rd;
  logic       ifid_uses_rt, idex_wen, idex_load, exmem_wen;
  logic       ihit, dhit, dmemREN, dmemWEN, branch_taken, jump, halt;

  logic a_sifid, a_sidex, a_sxmem, a_swb, a_fifid, a_fidex, a_fxmem, a_fwb, a_pc, a_hl;
  logic b_sifid, b_sidex, b_sxmem, b_swb, b_fifid, b_fidex, b_fxmem, b_fwb, b_pc, b_hl;
  logic [31:0] a_cyc;
  logic [3:0]  b_cyc;

  hazard_ctrl #(.REG_W(5), .LOAD_USE_BUBBLES(2), .FORWARD_EN(1), .CNT_W(32)) dut_a (
    .CLK(CLK), .nRST(nRST), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_uses_rt(ifid_uses_rt), .idex_rd(idex_rd), .idex_wen(idex_wen),
    .idex_load(idex_load), .exmem_rd(exmem_rd), .exmem_wen(exmem_wen),
    .ihit(ihit), .dhit(dhit), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .branch_taken(branch_taken), .jump(jump), .halt(halt),
    .stall_ifid(a_sifid), .stall_idex(a_sidex), .stall_xmem(a_sxmem), .stall_wb(a_swb),
    .flush_ifid(a_fifid), .flush_idex(a_fidex), .flush_xmem(a_fxmem), .flush_wb(a_fwb),
    .pc_en(a_pc), .halted(a_hl), .stall_cycles(a_cyc));

  hazard_ctrl #(.REG_W(5), .LOAD_USE_BUBBLES(3), .FORWARD_EN(0), .CNT_W(4)) dut_b (
    .CLK(CLK), .nRST(nRST), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_uses_rt(ifid_uses_rt), .idex_rd(idex_rd), .idex_wen(idex_wen),
    .idex_load(idex_load), .exmem_rd(exmem_rd), .exmem_wen(exmem_wen),
    .ihit(ihit), .dhit(dhit), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .branch_taken(branch_taken), .jump(jump), .halt(halt),
    .stall_ifid(b_sifid), .stall_idex(b_sidex), .stall_xmem(b_sxmem), .stall_wb(b_swb),
    .flush_ifid(b_fifid), .flush_idex(b_fidex), .flush_xmem(b_fxmem), .flush_wb(b_fwb),
    .pc_en(b_pc), .halted(b_hl), .stall_cycles(b_cyc));

  // {stalls[3:0], flushes[3:0], pc_en, halted}; latch order ifid, idex, xmem, wb
  logic [3:0] a_st, a_fl, b_st, b_fl;
  assign a_st = {a_sifid, a_sidex, a_sxmem, a_swb};
  assign a_fl = {a_fifid, a_fidex, a_fxmem, a_fwb};
  assign b_st = {b_sifid, b_sidex, b_sxmem, b_swb};
  assign b_fl = {b_fifid, b_fidex, b_fxmem, b_fwb};

  typedef struct packed { logic [3:0] st; logic [3:0] fl; logic pc; logic hl; } outs_t;
  typedef struct { outs_t o; longint cyc; } exp_t;
  typedef struct { bit halted; int left; longint cyc; } mdl_t;
  typedef struct {
    int rs, rt, idrd, exrd;
    bit uses_rt, id_wen, id_load, ex_wen, ihit, dhit, ren, wen, br, jmp, halt, rst;
  } in_t;

  exp_t qa[$], qb[$];
  mdl_t ma, mb;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic bit dep(input int rd, input in_t i);
    return (rd != 0) && ((rd == i.rs) || (i.uses_rt && (rd == i.rt)));
  endfunction

  // Reference model: `left` is the number of further forced bubble cycles
  // still owed for a load-use hazard; `cyc` is the stall-cycle tally.
  function automatic void predict(input int fwd, input int lub, input longint cmax,
                                  input in_t i, input mdl_t m,
                                  output exp_t e, output mdl_t n);
    bit busy, lu, raw;
    n = m;
    e.o = '0;
    e.cyc = m.cyc;
    if (i.rst) begin
      e.o.fl = 4'hF;
      e.cyc = 0;
      n.halted = 0; n.left = 0; n.cyc = 0;
      return;
    end
    if (m.halted) begin
      e.o.st = 4'hF;
      e.o.hl = 1'b1;
      return;
    end
    busy = (i.ren || i.wen) && !i.dhit;
    lu   = i.id_load && i.id_wen && dep(i.idrd, i);
    raw  = (fwd == 0) && ((i.id_wen && dep(i.idrd, i)) || (i.ex_wen && dep(i.exrd, i)));
    e.o.pc = i.ihit;
    if (i.halt && !busy) begin
      e.o.fl = 4'b1110; e.o.pc = 1'b0; n.halted = 1; n.left = 0;
    end else if (busy) begin
      e.o.st = 4'b1110; e.o.fl = 4'b0001; e.o.pc = 1'b0;
    end else if (i.br || i.jmp) begin
      e.o.fl = 4'b1100; e.o.pc = 1'b1; n.left = 0;
    end else if (m.left > 0) begin
      e.o.st = 4'b1000; e.o.fl = 4'b0100; e.o.pc = 1'b0; n.left = m.left - 1;
    end else if (lu || raw) begin
      e.o.st = 4'b1000; e.o.fl = 4'b0100; e.o.pc = 1'b0;
      if (lu) n.left = lub - 1;
    end else if (!i.ihit) begin
      e.o.fl = 4'b1000;
    end
    if (!e.o.pc) n.cyc = (m.cyc >= cmax) ? cmax : m.cyc + 1;
  endfunction

  function automatic in_t idle();
    in_t i;
    i = '{default: 0};
    i.ihit = 1; i.dhit = 1;
    return i;
  endfunction

  function automatic in_t rand_in();
    in_t i;
    i.rs = $urandom_range(0, 3);   i.rt = $urandom_range(0, 3);
    i.idrd = $urandom_range(0, 3); i.exrd = $urandom_range(0, 3);
    i.uses_rt = $urandom_range(0, 1) == 1;
    i.id_wen  = $urandom_range(0, 1) == 1;
    i.id_load = $urandom_range(0, 2) == 0;
    i.ex_wen  = $urandom_range(0, 1) == 1;
    i.ihit    = $urandom_range(0, 7) != 0;
    i.dhit    = $urandom_range(0, 2) != 0;
    i.ren     = $urandom_range(0, 3) == 0;
    i.wen     = $urandom_range(0, 7) == 0;
    i.br      = $urandom_range(0, 9) == 0;
    i.jmp     = $urandom_range(0, 19) == 0;
    i.halt    = $urandom_range(0, 49) == 0;
    i.rst     = $urandom_range(0, 79) == 0;
    return i;
  endfunction

  task automatic step(input in_t i);
    exp_t ea, eb;
    @(posedge CLK);
    #1;
    nRST = !i.rst;
    ifid_rs = 5'(i.rs); ifid_rt = 5'(i.rt); idex_rd = 5'(i.idrd); exmem_rd = 5'(i.exrd);
    ifid_uses_rt = i.uses_rt; idex_wen = i.id_wen; idex_load = i.id_load;
    exmem_wen = i.ex_wen; ihit = i.ihit; dhit = i.dhit; dmemREN = i.ren;
    dmemWEN = i.wen; branch_taken = i.br; jump = i.jmp; halt = i.halt;
    predict(1, 2, 64'hFFFF_FFFF, i, ma, ea, ma);
    predict(0, 3, 15, i, mb, eb, mb);
    qa.push_back(ea);
    qb.push_back(eb);
    #1;
  endtask

  task automatic do_reset();
    in_t i;
    i = idle();
    i.rst = 1;
    step(i);
    step(i);
  endtask

  exp_t ea_m, eb_m;
  always @(negedge CLK) begin
    if (qa.size() > 0) begin
      ea_m = qa.pop_front();
      chk("A_outs", {a_st, a_fl, a_pc, a_hl}, ea_m.o);
      chk("A_stall_cycles", a_cyc, ea_m.cyc);
    end
    if (qb.size() > 0) begin
      eb_m = qb.pop_front();
      chk("B_outs", {b_st, b_fl, b_pc, b_hl}, eb_m.o);
      chk("B_stall_cycles", b_cyc, eb_m.cyc);
    end
  end

  initial begin
    in_t i;
    ma = '{default: 0};
    mb = '{default: 0};
    nRST = 1'b0;
    ifid_rs = '0; ifid_rt = '0; idex_rd = '0; exmem_rd = '0;
    ifid_uses_rt = 0; idex_wen = 0; idex_load = 0; exmem_wen = 0;
    ihit = 1; dhit = 1; dmemREN = 0; dmemWEN = 0; branch_taken = 0; jump = 0; halt = 0;

    do_reset();
    chk("reset_flushes", a_fl, 4'hF);
    chk("reset_pc_en", a_pc, 0);

    // Register 0 load never stalls
    i = idle(); i.id_load = 1; i.id_wen = 1; i.idrd = 0; i.rs = 0;
    step(i);
    chk("reg0_pc_en", a_pc, 1);
    chk("reg0_stall", a_st, 4'b0000);

    // Load-use with two bubbles on instance A
    i = idle(); i.id_load = 1; i.id_wen = 1; i.idrd = 5; i.rs = 5;
    step(i);
    chk("lu_c1_stall", a_st, 4'b1000);
    chk("lu_c1_flush", a_fl, 4'b0100);
    step(idle());
    chk("lu_c2_pc_en", a_pc, 0);
    step(idle());
    chk("lu_done_pc_en", a_pc, 1);
    chk("lu_stall_cycles", a_cyc, 2);

    // dcache miss in the middle of a bubble
    do_reset();
    i = idle(); i.id_load = 1; i.id_wen = 1; i.idrd = 5; i.rs = 5;
    step(i);
    i = idle(); i.ren = 1; i.dhit = 0;
    for (int k = 0; k < 3; k++) begin
      step(i);
      chk("miss_stall", a_st, 4'b1110);
      chk("miss_flush", a_fl, 4'b0001);
    end
    step(idle());
    chk("miss_resume_bubble", a_st, 4'b1000);
    step(idle());
    chk("miss_run_pc_en", a_pc, 1);

    // Redirect beats load-use
    i = idle(); i.id_load = 1; i.id_wen = 1; i.idrd = 5; i.rs = 5; i.br = 1;
    step(i);
    chk("redir_flush", a_fl, 4'b1100);
    chk("redir_stall", a_st, 4'b0000);
    chk("redir_pc_en", a_pc, 1);
    step(idle());
    chk("redir_next_pc_en", a_pc, 1);

    // RAW through MEM stage: stalls only without forwarding
    i = idle(); i.ex_wen = 1; i.exrd = 9; i.uses_rt = 1; i.rt = 9; i.rs = 0;
    step(i);
    chk("nofwd_stall", b_st, 4'b1000);
    chk("nofwd_flush", b_fl, 4'b0100);
    chk("fwd_no_stall", a_st, 4'b0000);

    // Halt behind a cache miss, then sticky halted, then reset
    do_reset();
    i = idle(); i.halt = 1; i.ren = 1; i.dhit = 0;
    step(i);
    chk("halt_busy_stall", a_st, 4'b1110);
    i.dhit = 1;
    step(i);
    chk("halt_flush", a_fl, 4'b1110);
    chk("halt_pc_en", a_pc, 0);
    for (int k = 0; k < 4; k++) step(idle());
    chk("halted_flag", a_hl, 1);
    chk("halted_stall", a_st, 4'hF);
    chk("halted_cycles_frozen", a_cyc, 2);
    i = idle(); i.rst = 1;
    step(i);
    chk("halted_reset_clear", a_hl, 0);

    // Randomized traffic
    for (int k = 0; k < 1500; k++) step(rand_in());

    @(posedge CLK);
    @(negedge CLK);
    #1;
    chk("queue_drain", qa.size() + qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
